// File: rtl/spi_xfer_ctrl_if.sv
// Handshake bundle between spi_xfer_ctrl and its TX FIFO, shift engine, RX FIFO and host.
// master = the controller side, slave = the surrounding FIFOs/engine/host.
interface spi_xfer_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [7:0]       burst_len;
    logic             tx_empty;
    logic [WIDTH-1:0] tx_dout;
    logic             tx_re;
    logic             eng_start;
    logic [WIDTH-1:0] eng_txd;
    logic             eng_done;
    logic [WIDTH-1:0] eng_rxd;
    logic             rx_full;
    logic             rx_we;
    logic [WIDTH-1:0] rx_din;
    logic             cs_n;
    logic             busy;
    logic             done;
    logic [7:0]       frame_cnt;
    logic             err_underrun;

    modport master (
        input  start, burst_len, tx_empty, tx_dout, eng_done, eng_rxd, rx_full,
        output tx_re, eng_start, eng_txd, rx_we, rx_din, cs_n, busy, done,
               frame_cnt, err_underrun
    );

    modport slave (
        output start, burst_len, tx_empty, tx_dout, eng_done, eng_rxd, rx_full,
        input  tx_re, eng_start, eng_txd, rx_we, rx_din, cs_n, busy, done,
               frame_cnt, err_underrun
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI burst controller: TX FIFO -> shift engine -> RX FIFO, cs_n held low across a burst.
// Latency: start edge N -> tx_re at N+1, eng_start at N+2; done one cycle after last rx_we.
// Backpressure: stalls in FETCH on tx_empty, in STORE on rx_full; SPI_XFER_TIMEOUT_EN aborts stuck FETCH.
module spi_xfer_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CS_GAP  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    spi_xfer_ctrl_if.master bus
);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, LAUNCH, SHIFT, STORE, GAP, FINISH
    } state_t;

    state_t           state;
    logic [7:0]       remaining;
    logic [7:0]       frame_cnt_q;
    logic [WIDTH-1:0] eng_txd_q;
    logic [WIDTH-1:0] rx_din_q;
    logic [GW-1:0]    gap_cnt;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("spi_xfer_ctrl: TIMEOUT must be 1..255");
    end

`ifdef SPI_XFER_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            remaining   <= 8'd0;
            frame_cnt_q <= 8'd0;
            eng_txd_q   <= '0;
            rx_din_q    <= '0;
            gap_cnt     <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
            to_cnt      <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.burst_len != 8'd0) begin
                        remaining   <= bus.burst_len;
                        frame_cnt_q <= 8'd0;
                        gap_cnt     <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
                        to_cnt      <= 8'd0;
                        err_q       <= 1'b0;
`endif
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (!bus.tx_empty) begin
                        eng_txd_q <= bus.tx_dout;
`ifdef SPI_XFER_TIMEOUT_EN
                        to_cnt    <= 8'd0;
`endif
                        state     <= LAUNCH;
                    end
`ifdef SPI_XFER_TIMEOUT_EN
                    // to_cnt counts empty cycles already seen; this one is number to_cnt+1
                    else if (to_cnt == 8'(TIMEOUT - 1)) begin
                        err_q     <= 1'b1;
                        remaining <= 8'd0;
                        to_cnt    <= 8'd0;
                        state     <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
`endif
                end
                LAUNCH: state <= SHIFT;
                SHIFT: begin
                    if (bus.eng_done) begin
                        rx_din_q <= bus.eng_rxd;
                        state    <= STORE;
                    end
                end
                STORE: begin
                    if (!bus.rx_full) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        remaining   <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= FINISH;
                        end else if (CS_GAP > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(CS_GAP - 1)) state <= FETCH;
                    else                            gap_cnt <= gap_cnt + GW'(1);
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pop/push strobes qualify on the live FIFO flags so a stalled cycle never moves data.
    assign bus.tx_re     = (state == FETCH) && !bus.tx_empty;
    assign bus.rx_we     = (state == STORE) && !bus.rx_full;
    assign bus.eng_start = (state == LAUNCH);
    assign bus.cs_n      = (state == IDLE) || (state == FINISH);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign bus.eng_txd   = eng_txd_q;
    assign bus.rx_din    = rx_din_q;
    assign bus.frame_cnt = frame_cnt_q;
`ifdef SPI_XFER_TIMEOUT_EN
    assign bus.err_underrun = err_q;
`else
    assign bus.err_underrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural TX FIFO, loopback shift engine and RX FIFO around the DUT.
module tb_spi_xfer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.WIDTH(8)) bus ();
    spi_xfer_ctrl #(.WIDTH(8), .CS_GAP(2), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_got[$];
    int n_start = 0;
    int n_done  = 0;
    int eng_cnt = 0;

    // TX FIFO flags registered, engine answers 3 edges after eng_start, RX FIFO records pushes
    always @(posedge clk) begin
        if (bus.tx_re) void'(tx_q.pop_front());
        bus.tx_empty <= (tx_q.size() == 0);
        bus.tx_dout  <= (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        if (bus.rx_we) rx_got.push_back(bus.rx_din);
        if (bus.eng_start) n_start <= n_start + 1;
        if (bus.done) n_done <= n_done + 1;
        bus.eng_done <= 1'b0;
        if (!rst)               eng_cnt <= 0;
        else if (bus.eng_start) eng_cnt <= 3;
        else if (eng_cnt > 0)   eng_cnt <= eng_cnt - 1;
        if (rst && !bus.eng_start && eng_cnt == 1) begin
            bus.eng_done <= 1'b1;
            bus.eng_rxd  <= bus.eng_txd;
        end
    end

    task automatic kick(input logic [7:0] len);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.burst_len = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cs_n, bus.busy, bus.done, bus.tx_re, bus.rx_we, bus.eng_start} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {bus.cs_n, bus.busy, bus.done, bus.tx_re, bus.rx_we, bus.eng_start});
        end
        checks++;
        if ({bus.eng_txd, bus.rx_din, bus.frame_cnt} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data: got %h want 000000", {bus.eng_txd, bus.rx_din, bus.frame_cnt});
        end
        checks++;
        if (bus.err_underrun !== 1'b0) begin
            failures++; $display("FAIL reset_err: got %b want 0", bus.err_underrun);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int s0, d0, cyc, first_we, second_re;
        bit ok, cs_bad;
        logic [7:0] e, g;
        tx_q.push_back(8'hA5); exp_q.push_back(8'hA5);
        tx_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        s0 = n_start; d0 = n_done;
        kick(8'd2);
        @(negedge clk);
        checks++;
        if (bus.tx_re !== 1'b1) begin failures++; $display("FAIL lat_tx_re: got %b want 1", bus.tx_re); end
        @(negedge clk);
        checks++;
        if (bus.eng_start !== 1'b1) begin failures++; $display("FAIL lat_eng_start: got %b want 1", bus.eng_start); end
        ok = 0; cs_bad = 0; first_we = -1; second_re = -1;
        for (cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin ok = 1; break; end
            if (bus.cs_n !== 1'b0) cs_bad = 1;
            if (bus.rx_we === 1'b1 && first_we < 0) first_we = cyc;
            if (bus.tx_re === 1'b1 && first_we >= 0 && second_re < 0) second_re = cyc;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done: got timeout want done pulse"); end
        checks++;
        if (cs_bad) begin failures++; $display("FAIL basic_cs_low: got cs_n high mid-burst want low"); end
        checks++;
        if (second_re - first_we != 3) begin
            failures++; $display("FAIL basic_gap: got %0d want 3", second_re - first_we);
        end
        checks++;
        if (bus.frame_cnt !== 8'd2) begin failures++; $display("FAIL basic_frame_cnt: got %0d want 2", bus.frame_cnt); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (rx_got.size() != 0) ? rx_got.pop_front() : 8'hxx;
            checks++;
            if (g !== e) begin failures++; $display("FAIL basic_rx_data: got %h want %h", g, e); end
        end
        @(negedge clk);
        checks++;
        if (n_start - s0 != 2) begin failures++; $display("FAIL basic_eng_starts: got %0d want 2", n_start - s0); end
        checks++;
        if ({bus.done, bus.busy, bus.cs_n} !== 3'b001 || n_done - d0 != 1) begin
            failures++;
            $display("FAIL basic_single_done: got done=%b busy=%b cs_n=%b pulses=%0d want 0 0 1 1",
                     bus.done, bus.busy, bus.cs_n, n_done - d0);
        end
    endtask

    task automatic test_rx_stall;
        bit ok; int bad;
        logic [7:0] g;
        tx_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        bus.rx_full = 1'b1;
        kick(8'd1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.eng_done === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_eng_done: got timeout want eng_done"); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rx_we !== 1'b0 || bus.cs_n !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        bus.rx_full = 1'b0;
        #1;
        checks++;
        if (bus.rx_we !== 1'b1) begin failures++; $display("FAIL stall_release: got rx_we=%b want 1", bus.rx_we); end
        wait_done(20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_done: got timeout want done pulse"); end
        g = (rx_got.size() == 1) ? rx_got.pop_front() : 8'hxx;
        checks++;
        if (g !== exp_q.pop_front() || bus.frame_cnt !== 8'd1) begin
            failures++; $display("FAIL stall_data: got %h cnt=%0d want 5a cnt=1", g, bus.frame_cnt);
        end
        rx_got.delete();
    endtask

`ifdef SPI_XFER_TIMEOUT_EN
    task automatic test_timeout;
        int s0; bit ok;
        logic [7:0] g;
        s0 = n_start;
        kick(8'd1);
        repeat (16) @(negedge clk);
        checks++;
        if (bus.err_underrun !== 1'b0 || bus.busy !== 1'b1 || bus.cs_n !== 1'b0) begin
            failures++; $display("FAIL to_early: got err=%b busy=%b want 0 1", bus.err_underrun, bus.busy);
        end
        @(negedge clk);
        checks++;
        if ({bus.err_underrun, bus.done, bus.cs_n} !== 3'b111) begin
            failures++;
            $display("FAIL to_fire: got err=%b done=%b cs_n=%b want 1 1 1", bus.err_underrun, bus.done, bus.cs_n);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.err_underrun !== 1'b1 || n_start != s0) begin
            failures++;
            $display("FAIL to_after: got busy=%b err=%b starts=%0d want 0 1 0", bus.busy, bus.err_underrun, n_start - s0);
        end
        tx_q.push_back(8'h42); exp_q.push_back(8'h42);
        kick(8'd1);
        @(negedge clk);
        checks++;
        if (bus.err_underrun !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", bus.err_underrun); end
        wait_done(40, ok);
        g = (rx_got.size() == 1) ? rx_got.pop_front() : 8'hxx;
        checks++;
        if (!ok || g !== exp_q.pop_front()) begin failures++; $display("FAIL to_recover: got ok=%b data=%h want 1 42", ok, g); end
        rx_got.delete();
    endtask
`else
    task automatic test_fetch_wait;
        int s0, bad; bit ok;
        logic [7:0] g;
        s0 = n_start; bad = 0;
        kick(8'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b0 || bus.busy !== 1'b1 || bus.tx_re !== 1'b0 || bus.err_underrun !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || n_start != s0) begin
            failures++; $display("FAIL fetch_wait: got %0d bad cycles, %0d starts want 0 0", bad, n_start - s0);
        end
        tx_q.push_back(8'h99); exp_q.push_back(8'h99);
        wait_done(40, ok);
        g = (rx_got.size() == 1) ? rx_got.pop_front() : 8'hxx;
        checks++;
        if (!ok || g !== exp_q.pop_front()) begin failures++; $display("FAIL fetch_resume: got ok=%b data=%h want 1 99", ok, g); end
        rx_got.delete();
    endtask
`endif

    task automatic test_ignore_start;
        int s0, bad; bit ok;
        logic [7:0] e, g;
        @(posedge clk); #1; bus.start = 1'b1; bus.burst_len = 8'd0;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin
            failures++; $display("FAIL zero_len: got busy=%b cs_n=%b want 0 1", bus.busy, bus.cs_n);
        end
        tx_q.push_back(8'h11); exp_q.push_back(8'h11);
        tx_q.push_back(8'h22); exp_q.push_back(8'h22);
        s0 = n_start;
        kick(8'd2);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; bus.start = 1'b1; bus.burst_len = 8'd5;
        @(posedge clk); #1; bus.start = 1'b0;
        wait_done(100, ok);
        checks++;
        if (!ok || bus.frame_cnt !== 8'd2 || n_start - s0 != 2) begin
            failures++;
            $display("FAIL busy_start: got ok=%b cnt=%0d starts=%0d want 1 2 2", ok, bus.frame_cnt, n_start - s0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = (rx_got.size() != 0) ? rx_got.pop_front() : 8'hxx;
            checks++;
            if (g !== e) begin failures++; $display("FAIL busy_rx_data: got %h want %h", g, e); end
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL busy_no_restart: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_mid_reset;
        int seen; bit ok;
        logic [7:0] g;
        for (int i = 0; i < 4; i++) tx_q.push_back(8'hD0 + 8'(i));
        kick(8'd4);
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.eng_start === 1'b1) seen++;
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.cs_n, bus.busy, bus.done, bus.tx_re, bus.rx_we, bus.eng_start} !== 6'b100000 || seen != 2) begin
            failures++;
            $display("FAIL midrst_ctrl: got %b seen=%0d want 100000 seen=2",
                     {bus.cs_n, bus.busy, bus.done, bus.tx_re, bus.rx_we, bus.eng_start}, seen);
        end
        checks++;
        if ({bus.eng_txd, bus.rx_din, bus.frame_cnt, bus.err_underrun} !== 25'h0) begin
            failures++;
            $display("FAIL midrst_data: got txd=%h rxd=%h cnt=%0d err=%b want 0",
                     bus.eng_txd, bus.rx_din, bus.frame_cnt, bus.err_underrun);
        end
        tx_q.delete(); exp_q.delete(); rx_got.delete();
        repeat (2) @(negedge clk);
        tx_q.push_back(8'h77); exp_q.push_back(8'h77);
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.burst_len = 8'd1;
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL first_start_after_rst: got busy=%b want 1", bus.busy); end
        wait_done(40, ok);
        g = (rx_got.size() == 1) ? rx_got.pop_front() : 8'hxx;
        checks++;
        if (!ok || g !== exp_q.pop_front() || bus.frame_cnt !== 8'd1) begin
            failures++; $display("FAIL midrst_resume: got ok=%b data=%h cnt=%0d want 1 77 1", ok, g, bus.frame_cnt);
        end
        rx_got.delete();
    endtask

    task automatic test_long_burst;
        int bad, n; bit ok;
        logic [7:0] v;
        for (int i = 0; i < 255; i++) begin
            v = 8'(i * 7 + 3);
            tx_q.push_back(v); exp_q.push_back(v);
        end
        kick(8'd255);
        wait_done(6000, ok);
        checks++;
        if (!ok || bus.frame_cnt !== 8'd255) begin
            failures++; $display("FAIL long_cnt: got ok=%b cnt=%0d want 1 255", ok, bus.frame_cnt);
        end
        n = rx_got.size(); bad = 0;
        while (exp_q.size() != 0) begin
            v = exp_q.pop_front();
            if (rx_got.size() == 0 || rx_got.pop_front() !== v) bad++;
        end
        checks++;
        if (bad != 0 || n != 255) begin
            failures++; $display("FAIL long_data: got %0d frames %0d wrong want 255 0", n, bad);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.burst_len = 8'd0; bus.rx_full = 1'b0;
        test_reset;
        test_basic;
        test_rx_stall;
`ifdef SPI_XFER_TIMEOUT_EN
        test_timeout;
`else
        test_fetch_wait;
`endif
        test_ignore_start;
        test_mid_reset;
        test_long_burst;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, frame width in bits; CS_GAP, default 2, idle cycles between frames with cs_n held low (0 allowed); TIMEOUT, default 16, FETCH wait limit in cycles (1..255).
REQ-002 clk  in  1  clock, all state updated on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  single-cycle burst request, sampled in IDLE only.
REQ-005 burst_len  in  8  frames in burst, sampled with start.
REQ-006 tx_empty  in  1  TX FIFO empty flag.
REQ-007 tx_dout  in  WIDTH  TX FIFO head data, valid whenever tx_empty=0.
REQ-008 tx_re  out  1  TX FIFO pop strobe.
REQ-009 eng_start  out  1  shift-engine launch pulse.
REQ-010 eng_txd  out  WIDTH  frame to transmit, stable from eng_start until eng_done.
REQ-011 eng_done  in  1  shift-engine frame-complete pulse.
REQ-012 eng_rxd  in  WIDTH  received frame, valid while eng_done=1.
REQ-013 rx_full  in  1  RX FIFO full flag.
REQ-014 rx_we  out  1  RX FIFO push strobe.
REQ-015 rx_din  out  WIDTH  RX FIFO write data.
REQ-016 cs_n  out  1  chip select, active-low.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 done  out  1  one-cycle burst-end pulse.
REQ-019 frame_cnt  out  8  frames stored in the current burst.
REQ-020 err_underrun  out  1  sticky TX underrun abort flag.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, LAUNCH, SHIFT, STORE, GAP, FINISH; outputs SHALL decode from registered state, except tx_re and rx_we, which also gate on tx_empty and rx_full.
REQ-022 IDLE: start=1 with burst_len!=0 SHALL load remaining=burst_len, clear frame_cnt and err_underrun, and move to FETCH; start with burst_len=0 SHALL be ignored.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 cs_n SHALL be 0 in FETCH, LAUNCH, SHIFT, STORE and GAP, and 1 in IDLE and FINISH.
REQ-025 FETCH with tx_empty=0: tx_re=1 for exactly one cycle, tx_dout captured into eng_txd on that edge, next state LAUNCH.
REQ-026 FETCH with tx_empty=1: tx_re=0 and the FSM SHALL remain in FETCH.
REQ-027 LAUNCH: eng_start=1 for one cycle, then SHIFT.
REQ-028 SHIFT: wait for eng_done; on eng_done=1, capture eng_rxd into rx_din and go to STORE.
REQ-029 STORE with rx_full=0: rx_we=1 for one cycle, frame_cnt+1, remaining-1; next state is FINISH if remaining was 1, else GAP if CS_GAP>0, else FETCH.
REQ-030 STORE with rx_full=1: rx_we=0 and the FSM stalls in STORE, cs_n held low, no frame dropped.
REQ-031 GAP: stay exactly CS_GAP cycles, then FETCH.
REQ-032 FINISH: done=1 for one cycle, then IDLE.
REQ-033 Latency: start sampled at edge N gives tx_re at N+1 (if data present), eng_start at N+2 and done no earlier than one cycle after the last rx_we.
REQ-034 burst_len=255 SHALL complete 255 frames; frame_cnt SHALL NOT wrap within a burst.

Reset
REQ-035 rst=0 SHALL force IDLE immediately, including mid-burst, with cs_n=1, busy=0, done=0, tx_re=0, rx_we=0, eng_start=0, eng_txd=0, rx_din=0, frame_cnt=0, err_underrun=0.
REQ-036 After rst deasserts, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-037 With SPI_XFER_TIMEOUT_EN defined, FETCH SHALL count consecutive tx_empty=1 cycles; when the count reaches TIMEOUT, the block SHALL set err_underrun=1, discard remaining frames and go to FINISH (cs_n=1, done pulse).
REQ-038 Without SPI_XFER_TIMEOUT_EN, FETCH SHALL wait indefinitely, err_underrun SHALL be tied to 0 and no timeout counter SHALL be built.

Verification
REQ-039 TX FIFO holds A5,3C; burst_len=2; CS_GAP=2; engine loopback -> two eng_start pulses, rx_din A5 then 3C, frame_cnt=2, single done pulse, cs_n low continuously between the two frames.
REQ-040 rx_full=1 for 10 cycles at first STORE -> rx_we stays 0 and the FSM holds in STORE for those 10 cycles, then one rx_we; no data lost.
REQ-041 TX FIFO empty, burst_len=1, macro defined, TIMEOUT=16 -> after 16 cycles err_underrun=1, done pulse, cs_n=1, no eng_start.
REQ-042 rst pulsed low during SHIFT of frame 2 of 4 -> cs_n=1, busy=0 and all outputs at reset values asynchronously; a new start works normally.
REQ-043 start with burst_len=0, then start asserted while busy -> no state change in either case; the in-flight burst completes unaffected.
